// File: rtl/ppu_pkg.sv
// Shared PPU types and constants for the background fetch path.
//   PIX_W            - colour index width, matches the background pixel FIFO width
//   MAP0/MAP1_BASE   - tile-map bases selected by LCDC.3
//   TILE_SIGNED_BASE - tile-data base for signed (LCDC.4 = 0) tile indices
//   fetch_state_e    - background fetcher state encoding
//   pixel_t          - one colour index
package ppu_pkg;

    localparam int unsigned PIX_W            = 2;
    localparam int unsigned MAP0_BASE        = 32'h1800;
    localparam int unsigned MAP1_BASE        = 32'h1C00;
    localparam int unsigned TILE_SIGNED_BASE = 32'h1000;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        StIdle,
        StMap,
        StLo,
        StHi,
        StPush
    } fetch_state_e;

endpackage

// File: rtl/bg_fetch_addr.sv
// Combinational VRAM address generator for the background tile fetcher.
// Inputs : ly_in, scy_in      - scanline and vertical scroll (latched per line)
//          scx_tile_in        - scx >> 3 (latched per line)
//          fetch_x_in         - tile counter within the line
//          tile_idx_in        - tile index read from the map
//          map_sel_in         - LCDC.3 map select
//          tile_unsigned_in   - LCDC.4 tile-data addressing mode
// Outputs: map_addr_out, lo_addr_out, hi_addr_out - VRAM-relative byte addresses
module bg_fetch_addr
    import ppu_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic [7:0]        ly_in,
    input  logic [7:0]        scy_in,
    input  logic [4:0]        scx_tile_in,
    input  logic [4:0]        fetch_x_in,
    input  logic [7:0]        tile_idx_in,
    input  logic              map_sel_in,
    input  logic              tile_unsigned_in,
    output logic [ADDR_W-1:0] map_addr_out,
    output logic [ADDR_W-1:0] lo_addr_out,
    output logic [ADDR_W-1:0] hi_addr_out
);

    logic [7:0]        w_y;
    logic [4:0]        w_col;
    logic [ADDR_W-1:0] w_map_base;
    logic [ADDR_W-1:0] w_tile_base;

    // Both sums wrap naturally in their widths: y mod 256, column mod 32.
    assign w_y   = ly_in + scy_in;
    assign w_col = scx_tile_in + fetch_x_in;

    assign w_map_base   = map_sel_in ? ADDR_W'(MAP1_BASE) : ADDR_W'(MAP0_BASE);
    assign map_addr_out = w_map_base + ADDR_W'({w_y[7:3], w_col});

    // Signed mode: sign-extend idx*16 and offset from 0x1000 (range 0x0800-0x17FF).
    assign w_tile_base = tile_unsigned_in
        ? ADDR_W'({tile_idx_in, 4'b0000})
        : ADDR_W'(TILE_SIGNED_BASE)
          + ADDR_W'({{(ADDR_W-12){tile_idx_in[7]}}, tile_idx_in, 4'b0000});

    assign lo_addr_out = w_tile_base + ADDR_W'({w_y[2:0], 1'b0});
    assign hi_addr_out = lo_addr_out + ADDR_W'(1);

endmodule

// File: rtl/bg_tile_fetcher.sv
// Background tile fetcher: per scanline reads map/tile bytes from VRAM, decodes the two
// bitplanes and pushes 8 colour indices per tile (left-most first) into the BG pixel FIFO.
// Ports: clk_in/rst_in (async active-high), start_in/stop_in line control, ly/scx/scy and
//        LCDC bits (latched at start), VRAM read port (data one cycle after strobe),
//        FIFO write port with fifo_full_in backpressure, busy_out and done_out status.
module bg_tile_fetcher
    import ppu_pkg::*;
#(
    parameter int ADDR_W         = 13,
    parameter int TILES_PER_LINE = 21
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic              stop_in,
    input  logic [7:0]        ly_in,
    input  logic [7:0]        scx_in,
    input  logic [7:0]        scy_in,
    input  logic              lcdc_bg_map_in,
    input  logic              lcdc_tile_data_in,
    output logic              vram_rd_out,
    output logic [ADDR_W-1:0] vram_addr_out,
    input  logic [7:0]        vram_data_in,
    input  logic              fifo_full_in,
    output logic              fifo_wr_en_out,
    output logic [PIX_W-1:0]  fifo_data_out,
    output logic              busy_out,
    output logic              done_out
);

    localparam logic [4:0] LAST_X = 5'(TILES_PER_LINE - 1);

    fetch_state_e r_state;
    logic         r_phase;
    logic [2:0]   r_pix;
    logic [4:0]   r_fetch_x;
    logic [7:0]   r_ly;
    logic [7:0]   r_scy;
    logic [4:0]   r_scx_tile;
    logic         r_map_sel;
    logic         r_tile_unsigned;
    logic [7:0]   r_idx;
    logic [7:0]   r_lo;
    logic [7:0]   r_hi;

    logic [ADDR_W-1:0] w_map_addr;
    logic [ADDR_W-1:0] w_lo_addr;
    logic [ADDR_W-1:0] w_hi_addr;
    logic              w_rd;
    logic              w_wr;
    logic [2:0]        w_bit;
    pixel_t            w_pix;
    logic              w_unused_scx;

    // Fine X scroll is dropped downstream, so only the tile column is kept.
    assign w_unused_scx = ^scx_in[2:0];

    bg_fetch_addr #(
        .ADDR_W(ADDR_W)
    ) u_addr (
        .ly_in           (r_ly),
        .scy_in          (r_scy),
        .scx_tile_in     (r_scx_tile),
        .fetch_x_in      (r_fetch_x),
        .tile_idx_in     (r_idx),
        .map_sel_in      (r_map_sel),
        .tile_unsigned_in(r_tile_unsigned),
        .map_addr_out    (w_map_addr),
        .lo_addr_out     (w_lo_addr),
        .hi_addr_out     (w_hi_addr)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state         <= StIdle;
            r_phase         <= 1'b0;
            r_pix           <= '0;
            r_fetch_x       <= '0;
            r_ly            <= '0;
            r_scy           <= '0;
            r_scx_tile      <= '0;
            r_map_sel       <= 1'b0;
            r_tile_unsigned <= 1'b0;
            r_idx           <= '0;
            r_lo            <= '0;
            r_hi            <= '0;
        end else if (stop_in) begin
            r_state <= StIdle;
            r_phase <= 1'b0;
            r_pix   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (start_in) begin
                        r_ly            <= ly_in;
                        r_scy           <= scy_in;
                        r_scx_tile      <= scx_in[7:3];
                        r_map_sel       <= lcdc_bg_map_in;
                        r_tile_unsigned <= lcdc_tile_data_in;
                        r_fetch_x       <= '0;
                        r_phase         <= 1'b0;
                        r_state         <= StMap;
                    end
                end
                StMap: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_idx   <= vram_data_in;
                        r_state <= StLo;
                    end
                end
                StLo: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_lo    <= vram_data_in;
                        r_state <= StHi;
                    end
                end
                StHi: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_hi    <= vram_data_in;
                        r_pix   <= '0;
                        r_state <= StPush;
                    end
                end
                StPush: begin
                    if (!fifo_full_in) begin
                        r_pix <= r_pix + 3'd1;
                        if (r_pix == 3'd7) begin
                            r_fetch_x <= r_fetch_x + 5'd1;
                            r_state   <= (r_fetch_x == LAST_X) ? StIdle : StMap;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Outputs decode registered state only (plus the FIFO handshake), so an async reset
    // clears them immediately.
    assign w_rd = (r_state == StMap || r_state == StLo || r_state == StHi) && !r_phase;
    assign w_wr = (r_state == StPush) && !fifo_full_in && !stop_in;

    always_comb begin
        vram_addr_out = '0;
        if (w_rd) begin
            case (r_state)
                StMap:   vram_addr_out = w_map_addr;
                StLo:    vram_addr_out = w_lo_addr;
                StHi:    vram_addr_out = w_hi_addr;
                default: vram_addr_out = '0;
            endcase
        end
    end

    assign w_bit = 3'd7 - r_pix;
    assign w_pix = {r_hi[w_bit], r_lo[w_bit]};

    assign vram_rd_out    = w_rd;
    assign fifo_wr_en_out = w_wr;
    assign fifo_data_out  = w_wr ? w_pix : '0;
    assign busy_out       = (r_state != StIdle);
    assign done_out       = w_wr && (r_pix == 3'd7) && (r_fetch_x == LAST_X);

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// Scoreboard bench for bg_tile_fetcher: a line-level reference model pushes expected VRAM
// reads and FIFO writes into queues; a negedge monitor pops and compares them.
module tb_bg_tile_fetcher;

    localparam int TPL = 21;
    localparam int NONE = 1 << 30;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  ly = '0;
    logic [7:0]  scx = '0;
    logic [7:0]  scy = '0;
    logic        map_sel = 1'b0;
    logic        tile_uns = 1'b0;
    logic        vram_rd;
    logic [12:0] vram_addr;
    logic [7:0]  vram_data = '0;
    logic        full = 1'b0;
    logic        wr_en;
    logic [1:0]  wr_data;
    logic        busy;
    logic        done;

    bg_tile_fetcher dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .start_in         (start),
        .stop_in          (stop),
        .ly_in            (ly),
        .scx_in           (scx),
        .scy_in           (scy),
        .lcdc_bg_map_in   (map_sel),
        .lcdc_tile_data_in(tile_uns),
        .vram_rd_out      (vram_rd),
        .vram_addr_out    (vram_addr),
        .vram_data_in     (vram_data),
        .fifo_full_in     (full),
        .fifo_wr_en_out   (wr_en),
        .fifo_data_out    (wr_data),
        .busy_out         (busy),
        .done_out         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int cyc;
        bit chk;
    } rd_t;

    typedef struct {
        int pix;
        bit dn;
        int cyc;
        bit chk;
    } wr_t;

    logic [7:0] mem [0:8191];
    rd_t  rd_q[$];
    wr_t  wr_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   wr_cnt = 0;
    int   done_cnt = 0;

    // VRAM: data valid exactly one cycle after the strobe, garbage otherwise.
    always @(posedge clk) vram_data <= vram_rd ? mem[vram_addr] : 8'($urandom);
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name, input int act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got 0x%0h, required no event (cycle %0d)", name, act, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a whole line computed from the addressing and decode rules.
    // Events at or after stall_cyc are delayed by stall_len; only max_w writes expected.
    task automatic push_line(input int l, input int sx, input int sy, input bit m1,
                             input bit uns, input bit chk, input int base, input int max_w,
                             input int stall_cyc, input int stall_len);
        int y, row, fine, col, maddr, idx, tbase, lo, lob, hib, w, uc;
        y = (l + sy) % 256;
        row = y / 8;
        fine = y % 8;
        w = 0;
        for (int t = 0; t < TPL; t++) begin
            if (t * 8 >= max_w) break;
            col = (sx / 8 + t) % 32;
            maddr = (m1 ? 'h1C00 : 'h1800) + row * 32 + col;
            idx = int'(mem[maddr]);
            tbase = uns ? idx * 16 : 'h1000 + (idx < 128 ? idx : idx - 256) * 16;
            lo = tbase + fine * 2;
            for (int r = 0; r < 3; r++) begin
                rd_t e;
                e.addr = (r == 0) ? maddr : (r == 1) ? lo : lo + 1;
                uc = base + 14 * t + 2 * r;
                e.cyc = uc + ((uc >= stall_cyc) ? stall_len : 0);
                e.chk = chk;
                rd_q.push_back(e);
            end
            lob = int'(mem[lo]);
            hib = int'(mem[lo + 1]);
            for (int k = 0; k < 8; k++) begin
                wr_t e;
                if (w < max_w) begin
                    e.pix = 2 * ((hib >> (7 - k)) & 1) + ((lob >> (7 - k)) & 1);
                    e.dn = (t == TPL - 1) && (k == 7);
                    uc = base + 6 + 14 * t + k;
                    e.cyc = uc + ((uc >= stall_cyc) ? stall_len : 0);
                    e.chk = chk;
                    wr_q.push_back(e);
                    w++;
                end
            end
        end
    endtask

    task automatic start_line(input int l, input int sx, input int sy, input bit m1,
                              input bit uns, input bit chk, input int max_w,
                              input int stall_off, input int stall_len, output int base);
        step();
        ly = 8'(l);
        scx = 8'(sx);
        scy = 8'(sy);
        map_sel = m1;
        tile_uns = uns;
        start = 1'b1;
        base = cyc + 1;
        push_line(l, sx, sy, m1, uns, chk, base, max_w,
                  (stall_off == 0) ? NONE : base + stall_off, stall_len);
        step();
        start = 1'b0;
        // Scramble line parameters: the DUT must use its latched copies.
        ly = 8'($urandom);
        scx = 8'($urandom);
        scy = 8'($urandom);
        map_sel = 1'($urandom);
        tile_uns = 1'($urandom);
        check("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_drain(input int limit, input bit stall_rand, input bit poke_start);
        int n;
        n = 0;
        while ((rd_q.size() != 0 || wr_q.size() != 0) && n < limit) begin
            step();
            n++;
            full = stall_rand ? ($urandom_range(3) == 0) : 1'b0;
            start = poke_start && (wr_q.size() > 16) && ($urandom_range(7) == 0);
        end
        full = 1'b0;
        start = 1'b0;
        if (n >= limit) fail_evt("drain_timeout", rd_q.size() + wr_q.size());
        repeat (4) step();
        check("busy_idle_after_line", int'(busy), 0);
    endtask

    // Monitor / scoreboard.
    initial begin : monitor
        rd_t re;
        wr_t we;
        bit  chk_busy;
        chk_busy = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (chk_busy) check("busy_fall_after_done", int'(busy), 0);
                chk_busy = 0;
                if (vram_rd) begin
                    if (rd_q.size() == 0) fail_evt("unexpected_read", int'(vram_addr));
                    else begin
                        re = rd_q.pop_front();
                        check("read_addr", int'(vram_addr), re.addr);
                        if (re.chk) check("read_cycle", cyc, re.cyc);
                    end
                end
                if (wr_en) begin
                    wr_cnt++;
                    if (done) begin
                        done_cnt++;
                        chk_busy = 1;
                    end
                    if (wr_q.size() == 0) fail_evt("unexpected_write", int'(wr_data));
                    else begin
                        we = wr_q.pop_front();
                        check("pixel", int'(wr_data), we.pix);
                        check("done_flag", int'(done), int'(we.dn));
                        if (we.chk) check("write_cycle", cyc, we.cyc);
                    end
                end else if (done) begin
                    fail_evt("done_without_write", 1);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base, w0, d0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);

        // Reset: outputs low during and after.
        repeat (3) step();
        check("rst_rd", int'(vram_rd), 0);
        check("rst_addr", int'(vram_addr), 0);
        check("rst_wr", int'(wr_en), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        step();
        check("post_rst_data", int'(wr_data), 0);
        check("post_rst_done", int'(done), 0);

        // 1: basic fetch with exact timing.
        mem['h1800] = 8'h05;
        mem['h0050] = 8'hF0;
        mem['h0051] = 8'hCC;
        start_line(0, 0, 0, 0, 1, 1, 8 * TPL, 0, 0, base);
        wait_drain(600, 0, 0);

        // 2: signed addressing, fine Y = 2.
        mem['h1820] = 8'h80;
        start_line(10, 0, 0, 0, 0, 1, 8 * TPL, 0, 0, base);
        wait_drain(600, 0, 0);

        // 3: wrap-around of column and y.
        start_line(8, 'hF8, 'hFC, 1, 1, 1, 8 * TPL, 0, 0, base);
        wait_drain(600, 0, 0);

        // 4: five-cycle stall after the third pixel write of the first tile.
        start_line(3, 16, 40, 0, 1, 1, 8 * TPL, 9, 5, base);
        while (cyc < base + 9) step();
        full = 1'b1;
        repeat (5) step();
        full = 1'b0;
        wait_drain(600, 0, 0);

        // 5: full line with start_in pokes while busy.
        w0 = wr_cnt;
        d0 = done_cnt;
        start_line(100, 77, 5, 1, 0, 1, 8 * TPL, 0, 0, base);
        wait_drain(600, 0, 1);
        check("line_write_count", wr_cnt - w0, 8 * TPL);
        check("line_done_count", done_cnt - d0, 1);

        // 6a: abort during pixel 4 of the first tile, then restart from fetch_x = 0.
        start_line(50, 24, 9, 0, 1, 1, 4, 0, 0, base);
        while (cyc < base + 10) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("idle_after_stop", int'(busy), 0);
        repeat (20) step();
        check("stop_pending_reads", rd_q.size(), 0);
        check("stop_pending_writes", wr_q.size(), 0);
        start_line(50, 24, 9, 0, 1, 1, 8 * TPL, 0, 0, base);
        wait_drain(600, 0, 0);

        // stop beats start in the same cycle.
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        check("stop_beats_start", int'(busy), 0);
        repeat (5) step();

        // 6b: async reset in the HI read cycle.
        start_line(20, 0, 0, 0, 1, 1, 8 * TPL, 0, 0, base);
        while (cyc < base + 4) step();
        check("hi_read_before_reset", int'(vram_rd), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_rd", int'(vram_rd), 0);
        check("async_rst_addr", int'(vram_addr), 0);
        check("async_rst_wr", int'(wr_en), 0);
        check("async_rst_data", int'(wr_data), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_done", int'(done), 0);
        rd_q.delete();
        wr_q.delete();
        step();
        rst = 1'b0;
        step();
        check("busy_after_reset", int'(busy), 0);

        // Randomized lines, alternating exact-timing and random backpressure.
        for (int i = 0; i < 6; i++) begin
            bit st;
            st = (i % 2) == 1;
            start_line($urandom_range(255), $urandom_range(255), $urandom_range(255),
                       1'($urandom), 1'($urandom), !st, 8 * TPL, 0, 0, base);
            wait_drain(2000, st, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bg_tile_fetcher.md
Name: bg_tile_fetcher

Overview:
Background tile fetcher for the PPU pixel pipeline. It sits directly upstream of the background pixel FIFO.
- Per scanline, it reads tile-map and tile-data bytes from VRAM.
- It decodes the two bitplanes into 2-bit colour indices.
- It pushes 8 pixels per tile into the FIFO's write port, left-most pixel first.

Parameters:
ADDR_W, 13, VRAM byte address width (8 KiB VRAM, addresses VRAM-relative).
PIX_W, 2, colour index width; must match the FIFO WIDTH it drives.
TILES_PER_LINE, 21, tiles fetched per line (160/8 plus one for fine-scroll overlap).

Ports:
clk_in  in  1  system clock; all state changes on rising edge.
rst_in  in  1  asynchronous, active-high reset.
start_in  in  1  one-cycle pulse: begin fetching a scanline.
stop_in  in  1  one-cycle pulse: abort the current line (mode change / LCD off).
ly_in  in  8  current scanline.
scx_in  in  8  horizontal scroll.
scy_in  in  8  vertical scroll.
lcdc_bg_map_in  in  1  LCDC.3: 0 selects map 0x1800, 1 selects map 0x1C00.
lcdc_tile_data_in  in  1  LCDC.4: 1 selects unsigned 0x0000 base, 0 selects signed 0x1000 base.
vram_rd_out  out  1  VRAM read strobe.
vram_addr_out  out  ADDR_W  VRAM read address.
vram_data_in  in  8  read data, valid exactly one cycle after vram_rd_out.
fifo_full_in  in  1  downstream FIFO cannot accept a write this cycle.
fifo_wr_en_out  out  1  FIFO write enable.
fifo_data_out  out  PIX_W  pixel colour index.
busy_out  out  1  high from the cycle after start_in until line complete or aborted.
done_out  out  1  one-cycle pulse when the last pixel of tile TILES_PER_LINE-1 is written.

Behaviour:
Reset:
- rst_in asynchronously forces state IDLE.
- All outputs are 0 during and after reset: vram_rd_out, vram_addr_out, fifo_wr_en_out, fifo_data_out, busy_out, done_out.
- Internal counters and latched registers are cleared.

Line start and abort:
- start_in in IDLE latches ly_in, scx_in, scy_in, lcdc_bg_map_in and lcdc_tile_data_in for the whole line.
- It also clears fetch_x and enters MAP.
- start_in while busy is ignored.
- stop_in in any state returns to IDLE next edge. No FIFO write occurs in the stop_in cycle. stop_in beats start_in in the same cycle.

State machine: IDLE -> MAP -> LO -> HI -> PUSH -> (MAP | IDLE).
- MAP, LO and HI each take 2 cycles:
  - Phase 0 drives vram_rd_out=1 and vram_addr_out.
  - Phase 1 captures vram_data_in at its closing edge, with vram_rd_out=0.
- Address arithmetic:
  - y = (ly + scy) mod 256; row = y>>3; fine = y & 7.
  - col = ((scx>>3) + fetch_x) mod 32.
  - MAP address = map_base + row*32 + col.
  - Unsigned tile base = idx*16.
  - Signed tile base = 0x1000 + signed(idx)*16, with range 0x0800-0x17FF.
  - LO address = tile base + fine*2; HI address = LO address + 1.
- PUSH: 8 write slots. Pixel k (k=0..7) = {hi[7-k], lo[7-k]}.
  - fifo_wr_en_out = (state==PUSH) && !fifo_full_in.
  - While fifo_full_in=1, the pixel index holds and nothing is written. Stalls are unbounded.
- After pixel 7 is written:
  - fetch_x increments.
  - If fetch_x was TILES_PER_LINE-1, done_out pulses together with that last write, and the next state is IDLE with busy_out=0. Otherwise the next state is MAP.
- Unstalled tile period is 14 cycles:
  - start_in sampled at edge N.
  - vram_rd_out asserted in cycles N+1, N+3, N+5.
  - FIFO writes in cycles N+7..N+14.
  - Next MAP read in cycle N+15.
- No sub-tile discard of scx&7 here. The downstream consumer drops scx&7 pixels.

Decomposition:
Package ppu_pkg holds:
- the fetch state enum;
- the constants MAP0_BASE=0x1800, MAP1_BASE=0x1C00, TILE_SIGNED_BASE=0x1000;
- PIX_W;
- the pixel typedef.

One natural combinational sub-module, bg_fetch_addr, computes the MAP, LO and HI addresses from the latched scroll values, ly, fetch_x, tile index and LCDC bits.

Test Plan:
1. Basic fetch:
   - Setup: ly=0, scy=0, scx=0, lcdc_tile_data=1, map[0x1800]=0x05, vram[0x0050]=0xF0, vram[0x0051]=0xCC.
   - Stimulus: start_in, no stalls.
   - Required: reads at N+1/N+3/N+5 to 0x1800/0x0050/0x0051; writes 3,3,1,1,2,2,0,0 in cycles N+7..N+14.
2. Signed addressing and fine Y:
   - Setup: lcdc_tile_data=0, ly=10, scy=0, map[0x1820]=0x80.
   - Required: MAP read at 0x1820; LO read at 0x0804; HI read at 0x0805.
3. Wrap-around:
   - Setup: scx=0xF8, scy=0xFC, ly=8, lcdc_bg_map=1.
   - Required: first MAP read at 0x1C1F; second MAP read at 0x1C00; LO address uses fine=4.
4. Backpressure:
   - Stimulus: hold fifo_full_in=1 for 5 cycles after the 3rd pixel write.
   - Required: no writes during the stall; the remaining 5 pixels follow in order; the tile completes 5 cycles late.
5. Full line:
   - Stimulus: no stalls.
   - Required: exactly 168 writes; done_out pulses once, coincident with the 168th write; busy_out falls the next cycle; start_in during busy has no effect.
6. Abort and reset:
   - Stimulus: stop_in asserted during PUSH pixel 4.
   - Required: no further writes; IDLE next cycle; a fresh start_in restarts at fetch_x=0.
   - Stimulus: rst_in asserted mid-HI.
   - Required: all outputs drop to 0 immediately, without waiting for a clock edge.
